// File: rtl/stream_xbar_pkg.sv
// Shared types and helpers for the stream crossbar
// schedulers and arbiters.
package stream_xbar_pkg;

  typedef enum logic {
    SCHED_IDLE = 1'b0,
    SCHED_BUSY = 1'b1
  } sched_state_e;

  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Circular find-first-set: lowest set request at or
// after start_i, wrapping from N-1 back to 0.
module rr_priority_select
  import stream_xbar_pkg::*;
#(
  parameter int N = 2,
  parameter int W = clog2_min1(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] start_i,
  output logic         found_o,
  output logic [W-1:0] idx_o
);

  logic [2*N-1:0] dbl;
  int             sum;

  // Rotate the doubled vector so start lands at bit 0,
  // then pick the lowest set bit within one lap.
  always_comb begin
    dbl     = {req_i, req_i} >> start_i;
    found_o = 1'b0;
    idx_o   = '0;
    sum     = 0;
    for (int i = N - 1; i >= 0; i--) begin
      if (dbl[i]) begin
        found_o = 1'b1;
        sum     = int'(start_i) + i;
        if (sum >= N) sum = sum - N;
        idx_o   = W'(sum);
      end
    end
  end

endmodule

// File: rtl/stream_packet_scheduler.sv
// Per-master-port packet scheduler: round-robin grant
// held for a whole packet, plus per-packet beat count.
module stream_packet_scheduler
  import stream_xbar_pkg::*;
#(
  parameter  int S_DATA_COUNT = 2,
  parameter  int CNT_WIDTH    = 16,
  localparam int T_ID___WIDTH = clog2_min1(S_DATA_COUNT)
) (
  input  logic                    clk_i,
  input  logic                    rst_in,
  input  logic [S_DATA_COUNT-1:0] s_tvalid_i,
  input  logic [S_DATA_COUNT-1:0] s_tlast_i,
  output logic [S_DATA_COUNT-1:0] s_tready_o,
  output logic                    m_tvalid_o,
  input  logic                    m_tready_i,
  output logic                    grant_valid_o,
  output logic [T_ID___WIDTH-1:0] grant_id_o,
  output logic                    pkt_done_o,
  output logic [CNT_WIDTH-1:0]    pkt_len_o
);

  sched_state_e            state_q;
  logic [T_ID___WIDTH-1:0] rr_ptr_q;
  logic [T_ID___WIDTH-1:0] gid_q;
  logic                    gval_q;
  logic [CNT_WIDTH-1:0]    beat_q;
  logic                    done_q;
  logic [CNT_WIDTH-1:0]    len_q;

  logic [T_ID___WIDTH-1:0] nxt_id;
  logic [T_ID___WIDTH-1:0] srch;
  logic [CNT_WIDTH-1:0]    beat_d;
  logic                    found;
  logic [T_ID___WIDTH-1:0] win;
  logic                    hs;
  logic                    last;

  assign nxt_id =
    (gid_q == T_ID___WIDTH'(S_DATA_COUNT - 1))
      ? '0 : gid_q + 1'b1;

  // While busy the only arbitration happens at TLAST,
  // where the search begins just past the current grant.
  assign srch =
    (state_q == SCHED_BUSY) ? nxt_id : rr_ptr_q;

  assign beat_d = (&beat_q) ? beat_q : beat_q + 1'b1;

  assign m_tvalid_o = gval_q & s_tvalid_i[gid_q];
  assign last       = s_tlast_i[gid_q];
  assign hs         = m_tvalid_o & m_tready_i;

  assign grant_valid_o = gval_q;
  assign grant_id_o    = gid_q;
  assign pkt_done_o    = done_q;
  assign pkt_len_o     = len_q;

  rr_priority_select #(
    .N (S_DATA_COUNT),
    .W (T_ID___WIDTH)
  ) u_sel (
    .req_i   (s_tvalid_i),
    .start_i (srch),
    .found_o (found),
    .idx_o   (win)
  );

  // Route master TREADY back to the granted slave only.
  always_comb begin
    s_tready_o = '0;
    if (gval_q) s_tready_o[gid_q] = m_tready_i;
  end

  // Grant FSM, round-robin pointer and beat counter.
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state_q  <= SCHED_IDLE;
      rr_ptr_q <= '0;
      gid_q    <= '0;
      gval_q   <= 1'b0;
      beat_q   <= '0;
      done_q   <= 1'b0;
      len_q    <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        SCHED_IDLE: begin
          if (found) begin
            gid_q   <= win;
            gval_q  <= 1'b1;
            state_q <= SCHED_BUSY;
          end
        end
        SCHED_BUSY: begin
          if (hs && last) begin
            len_q    <= beat_d;
            done_q   <= 1'b1;
            rr_ptr_q <= nxt_id;
            beat_q   <= '0;
            if (found) begin
              gid_q <= win;
            end else begin
              gval_q  <= 1'b0;
              state_q <= SCHED_IDLE;
            end
          end else if (hs) begin
            beat_q <= beat_d;
          end
        end
        default: state_q <= SCHED_IDLE;
      endcase
    end
  end

endmodule
